lsu_mem_initiator: RTL and testbench

- Load/store initiator between the execute stage and the data-memory port.
- Accepts one load or store per transaction and checks natural alignment.
- Issues a doubleword-aligned request with byte-lane write mask and lane-shifted write data.
- Waits for the response, extracts and sign/zero-extends the load result, and reports errors (misaligned, timeout) to the pipeline.

---
 rtl/lsu_mem_initiator_if.sv | 49 ++++
 rtl/lsu_mem_initiator.sv | 161 ++++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_initiator_if.sv
`default_nettype none
// lsu_mem_initiator_if: pipeline request/result and data-memory port handshakes.
// Rev 1.0
interface lsu_mem_initiator_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic              in_ren;
  logic              in_wen;
  logic [1:0]        in_size;
  logic              in_unsigned;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_rdata;
  logic [1:0]        out_err;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_wen;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [7:0]        mem_req_wmask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_rdata;

  modport master (
    input  in_valid, in_ren, in_wen, in_size, in_unsigned, in_addr, in_wdata,
    output in_ready,
    output out_valid, out_rdata, out_err,
    input  out_ready,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready,
    input  mem_resp_valid, mem_resp_rdata
  );

  modport slave (
    output in_valid, in_ren, in_wen, in_size, in_unsigned, in_addr, in_wdata,
    input  in_ready,
    input  out_valid, out_rdata, out_err,
    output out_ready,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    output mem_req_ready,
    output mem_resp_valid, mem_resp_rdata
  );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_initiator.sv
`default_nettype none
// lsu_mem_initiator: one-at-a-time load/store initiator with alignment check and timeout.
// Rev 1.0
module lsu_mem_initiator #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  lsu_mem_initiator_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;
  // Counter runs from 0, so the last waiting cycle is TIMEOUT-1.
  localparam logic [7:0] TMO_LAST     = 8'(TIMEOUT - 1);

  state_t            state;
  logic [7:0]        tmo_cnt;
  logic [1:0]        lat_size;
  logic              lat_unsigned;
  logic              lat_wen;
  logic [2:0]        lat_off;

  logic              misaligned;
  logic [7:0]        wmask_base;
  logic              sext;
  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] load_data;

  always_comb begin
    misaligned = 1'b0;
    wmask_base = 8'h01;
    case (bus.in_size)
      2'b00: begin
        misaligned = 1'b0;
        wmask_base = 8'h01;
      end
      2'b01: begin
        misaligned = bus.in_addr[0];
        wmask_base = 8'h03;
      end
      2'b10: begin
        misaligned = |bus.in_addr[1:0];
        wmask_base = 8'h0F;
      end
      default: begin
        misaligned = |bus.in_addr[2:0];
        wmask_base = 8'hFF;
      end
    endcase
  end

  // Right-justify the addressed lane, then extend from the access size.
  always_comb begin
    lane      = bus.mem_resp_rdata >> {lat_off, 3'b000};
    sext      = ~lat_unsigned;
    load_data = lane;
    case (lat_size)
      2'b00:   load_data = {{(DATA_W-8){sext & lane[7]}},   lane[7:0]};
      2'b01:   load_data = {{(DATA_W-16){sext & lane[15]}}, lane[15:0]};
      2'b10:   load_data = {{(DATA_W-32){sext & lane[31]}}, lane[31:0]};
      default: load_data = lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= IDLE;
      tmo_cnt            <= 8'd0;
      lat_size           <= 2'b00;
      lat_unsigned       <= 1'b0;
      lat_wen            <= 1'b0;
      lat_off            <= 3'd0;
      bus.in_ready       <= 1'b1;
      bus.out_valid      <= 1'b0;
      bus.out_rdata      <= '0;
      bus.out_err        <= ERR_OK;
      bus.mem_req_valid  <= 1'b0;
      bus.mem_req_addr   <= '0;
      bus.mem_req_wen    <= 1'b0;
      bus.mem_req_wdata  <= '0;
      bus.mem_req_wmask  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            lat_size     <= bus.in_size;
            lat_unsigned <= bus.in_unsigned;
            lat_wen      <= bus.in_wen;
            lat_off      <= bus.in_addr[2:0];
            bus.in_ready <= 1'b0;
            if (bus.in_ren == bus.in_wen) begin
              state         <= DONE;
              bus.out_valid <= 1'b1;
              bus.out_err   <= ERR_ILLEGAL;
              bus.out_rdata <= '0;
            end else if (misaligned) begin
              state         <= DONE;
              bus.out_valid <= 1'b1;
              bus.out_err   <= ERR_MISALIGN;
              bus.out_rdata <= '0;
            end else begin
              state             <= REQ;
              bus.mem_req_valid <= 1'b1;
              bus.mem_req_addr  <= {bus.in_addr[ADDR_W-1:3], 3'b000};
              bus.mem_req_wen   <= bus.in_wen;
              bus.mem_req_wdata <= bus.in_wdata << {bus.in_addr[2:0], 3'b000};
              bus.mem_req_wmask <= bus.in_wen ? (wmask_base << bus.in_addr[2:0]) : 8'h00;
            end
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            state             <= RESP;
            bus.mem_req_valid <= 1'b0;
            tmo_cnt           <= 8'd0;
          end
        end
        RESP: begin
          // A response in the final waiting cycle still beats the timeout.
          if (bus.mem_resp_valid) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.out_err   <= ERR_OK;
            bus.out_rdata <= lat_wen ? '0 : load_data;
          end else if (tmo_cnt == TMO_LAST) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.out_err   <= ERR_TIMEOUT;
            bus.out_rdata <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_err   <= ERR_OK;
            bus.out_rdata <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_initiator.sv
`default_nettype none
// tb_lsu_mem_initiator: directed and randomized load/store transactions against a byte-level model.
// Rev 1.0
module tb_lsu_mem_initiator;

  localparam int TMO = 16;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  lsu_mem_initiator_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  lsu_mem_initiator #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Byte-lane view of the access: which bytes move where, independent of any shifter.
  function automatic void model(
    input  logic        ren, wen,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [63:0] addr, wdata, rdata,
    output logic [1:0]  err,
    output logic [63:0] rd,
    output logic [7:0]  mask,
    output logic [63:0] wd
  );
    int bytes;
    int off;
    bytes = 1 << size;
    off   = int'(addr[2:0]);
    err = 2'b00; rd = '0; mask = '0; wd = '0;
    if (ren == wen)            err = 2'b11;
    else if (off % bytes != 0) err = 2'b01;
    for (int j = off; j < 8; j++) wd[8*j +: 8] = wdata[8*(j-off) +: 8];
    if (err == 2'b00 && wen)
      for (int i = 0; i < bytes; i++) mask[off+i] = 1'b1;
    if (err == 2'b00 && ren) begin
      for (int i = 0; i < bytes; i++) rd[8*i +: 8] = rdata[8*(off+i) +: 8];
      if (!uns && bytes < 8 && rd[8*bytes-1])
        for (int i = bytes; i < 8; i++) rd[8*i +: 8] = 8'hFF;
    end
  endfunction

  task automatic txn(
    input logic        ren, wen,
    input logic [1:0]  size,
    input logic        uns,
    input logic [63:0] addr, wdata, rdata,
    input int          req_dly, resp_dly, out_dly,
    input bit          no_resp
  );
    logic [1:0]  e_err;
    logic [63:0] e_rd, e_wd;
    logic [7:0]  e_mask;
    int          n;
    model(ren, wen, size, uns, addr, wdata, rdata, e_err, e_rd, e_mask, e_wd);
    if (no_resp && e_err == 2'b00) begin
      e_err = 2'b10;
      e_rd  = '0;
    end
    chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1; bus.in_ren = ren; bus.in_wen = wen; bus.in_size = size;
    bus.in_unsigned = uns; bus.in_addr = addr; bus.in_wdata = wdata;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_ren = 1'b0; bus.in_wen = 1'b0;
    bus.in_addr = {$urandom, $urandom}; bus.in_wdata = {$urandom, $urandom};
    chk("in_ready_busy", 64'(bus.in_ready), 64'd0);
    if (e_err == 2'b01 || e_err == 2'b11) begin
      chk("no_req_on_err", 64'(bus.mem_req_valid), 64'd0);
    end else begin
      for (int i = 0; i <= req_dly; i++) begin
        chk("req_valid", 64'(bus.mem_req_valid), 64'd1);
        chk("req_addr",  bus.mem_req_addr, {addr[63:3], 3'b000});
        chk("req_wen",   64'(bus.mem_req_wen), 64'(wen));
        chk("req_wmask", 64'(bus.mem_req_wmask), 64'(e_mask));
        if (wen) chk("req_wdata", bus.mem_req_wdata, e_wd);
        if (i == req_dly) bus.mem_req_ready = 1'b1;
        @(posedge clk); #1;
      end
      bus.mem_req_ready = 1'b0;
      chk("req_dropped", 64'(bus.mem_req_valid), 64'd0);
      if (no_resp) begin
        n = 0;
        while (!bus.out_valid && n < 40) begin
          @(posedge clk); #1;
          n++;
        end
        chk("timeout_cycles", 64'(n), 64'(TMO));
      end else begin
        repeat (resp_dly) begin
          chk("no_early_out", 64'(bus.out_valid), 64'd0);
          @(posedge clk); #1;
        end
        bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = rdata;
        @(posedge clk); #1;
        bus.mem_resp_valid = 1'b0; bus.mem_resp_rdata = {$urandom, $urandom};
      end
    end
    for (int i = 0; i <= out_dly; i++) begin
      chk("out_valid", 64'(bus.out_valid), 64'd1);
      chk("out_err",   64'(bus.out_err), 64'(e_err));
      chk("out_rdata", bus.out_rdata, e_rd);
      chk("in_ready_done", 64'(bus.in_ready), 64'd0);
      if (i == out_dly) bus.out_ready = 1'b1;
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    chk("out_released", 64'(bus.out_valid), 64'd0);
    chk("in_ready_back", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [2:0]  off;
    logic [63:0] a;
    int          r;
    tests = 0; fails = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_ren = 1'b0; bus.in_wen = 1'b0; bus.in_size = 2'b00;
    bus.in_unsigned = 1'b0; bus.in_addr = '0; bus.in_wdata = '0; bus.out_ready = 1'b0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_rdata", bus.out_rdata, 64'd0);
    chk("rst_out_err",   64'(bus.out_err), 64'd0);
    chk("rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
    chk("rst_req_addr",  bus.mem_req_addr, 64'd0);
    chk("rst_req_wen",   64'(bus.mem_req_wen), 64'd0);
    chk("rst_req_wdata", bus.mem_req_wdata, 64'd0);
    chk("rst_req_wmask", 64'(bus.mem_req_wmask), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases from the access table.
    txn(1, 0, 2'b00, 0, 64'h8000_0003, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0);
    txn(1, 0, 2'b10, 1, 64'h8000_0004, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0);
    txn(1, 0, 2'b10, 0, 64'h8000_0004, 64'h0, 64'h89AB_CDEF_0000_0000, 0, 0, 0, 0);
    txn(0, 1, 2'b01, 0, 64'h8000_0006, 64'hBEEF, 64'h1111_2222_3333_4444, 0, 0, 0, 0);
    txn(1, 0, 2'b10, 0, 64'h8000_0002, 64'h0, 64'h0, 0, 0, 0, 0);
    txn(1, 1, 2'b00, 0, 64'h8000_0000, 64'h0, 64'h0, 0, 0, 0, 0);
    txn(0, 0, 2'b11, 0, 64'h8000_0008, 64'h0, 64'h0, 0, 0, 0, 0);
    txn(1, 0, 2'b11, 1, 64'h8000_0010, 64'h0, 64'hF000_0000_0000_0001, 0, 0, 0, 0);

    // Timeout, then a stray response in IDLE.
    txn(1, 0, 2'b11, 0, 64'h8000_0020, 64'h0, 64'h0, 0, 0, 0, 1);
    bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge clk); #1;
    bus.mem_resp_valid = 1'b0;
    chk("late_resp_out_valid", 64'(bus.out_valid), 64'd0);
    chk("late_resp_in_ready",  64'(bus.in_ready), 64'd1);
    chk("late_resp_req",       64'(bus.mem_req_valid), 64'd0);

    // Stalls on both handshakes and a response coinciding with the timeout.
    txn(0, 1, 2'b10, 0, 64'h8000_0104, 64'hCAFE_F00D, 64'h0, 5, 2, 4, 0);
    txn(1, 0, 2'b01, 0, 64'h8000_000A, 64'h0, 64'h0000_8001_0000_0000, 0, TMO - 1, 0, 0);

    // Reset while waiting for a response drops the transaction.
    bus.in_valid = 1'b1; bus.in_ren = 1'b1; bus.in_wen = 1'b0; bus.in_size = 2'b11;
    bus.in_addr = 64'h8000_0040;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rstmid_in_ready",  64'(bus.in_ready), 64'd1);
    chk("rstmid_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rstmid_out_err",   64'(bus.out_err), 64'd0);
    chk("rstmid_req_valid", 64'(bus.mem_req_valid), 64'd0);
    chk("rstmid_req_addr",  bus.mem_req_addr, 64'd0);
    bus.mem_resp_valid = 1'b1;
    @(posedge clk); #1;
    bus.mem_resp_valid = 1'b0;
    chk("rstmid_resp_ignored", 64'(bus.out_valid), 64'd0);

    // Randomized transactions.
    for (int k = 0; k < 40; k++) begin
      sz = 2'($urandom_range(0, 3));
      r  = $urandom_range(0, 15);
      if ($urandom_range(0, 7) == 0) off = 3'($urandom);
      else off = 3'(($urandom_range(0, 7) >> sz) << sz);
      a = {$urandom, $urandom};
      a[2:0] = off;
      if (r == 0) begin
        r = $urandom_range(0, 1);
        txn(r[0], r[0], sz, 1'($urandom), a, {$urandom, $urandom}, {$urandom, $urandom},
            0, 0, $urandom_range(0, 2), 0);
      end else begin
        txn(r < 8, r >= 8, sz, 1'($urandom), a, {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 2), 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
